mc_fetch_unit: RTL and testbench

Program-counter, instruction-register and memory-access stage that sits directly downstream of the multicycle control state machine. It consumes the controller's per-state strobes (IorD, IRWrite, PCWrite, Branch, PCSrc), sequences every memory transaction over a req/ack bus, and holds the architectural PC, IR and memory data register (MDR). While a transaction is outstanding it asserts `stall` so the controller holds its current state.

---
 rtl/mc_pkg.sv | 18 +
 rtl/mc_pc_reg.sv | 43 ++++
 rtl/mc_fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_mc_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle fetch/memory stage: access-state
// encoding, PCSrc selector encodings and the default reset PC.
package mc_pkg;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_BUSY = 2'd1,
    ACC_DONE = 2'd2
  } acc_state_e;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_HOLD   = 2'd3;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/mc_pc_reg.sv
// Program counter: source mux, write enable and the architectural PC register.
// The jump target keeps the top four PC bits and splices in the 26-bit index.
module mc_pc_reg
  import mc_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [1:0]        src_i,
  input  logic [ADDR_W-1:0] alu_result_i,
  input  logic [ADDR_W-1:0] alu_out_i,
  input  logic [25:0]       jump_idx_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Select the next PC; an unasserted enable or the hold encoding keeps it.
  always_comb begin
    pc_d = pc_q;
    if (en_i) begin
      case (src_i)
        PCSRC_ALU:    pc_d = alu_result_i;
        PCSRC_ALUOUT: pc_d = alu_out_i;
        PCSRC_JUMP:   pc_d = {pc_q[ADDR_W-1:28], jump_idx_i, 2'b00};
        default:      pc_d = pc_q;
      endcase
    end
  end

  // PC register with synchronous reset to the configured boot address.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/mc_fetch_unit.sv
// PC / IR / MDR and memory-access stage of the multicycle datapath.
// Sequences one req/ack memory transaction per controller request and holds
// the controller with stall while it is outstanding.
// Optional feature macro: MC_FETCH_TIMEOUT_EN adds a BUSY wait-state limit
// that raises a sticky bus_err and freezes the controller.
module mc_fetch_unit
  import mc_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter logic [ADDR_W-1:0] RESET_PC       = ADDR_W'(RESET_PC_DEFAULT),
  parameter int unsigned       TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              IorD,
  input  logic              IRWrite,
  input  logic              PCWrite,
  input  logic              Branch,
  input  logic [1:0]        PCSrc,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic              zero,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] mdr,
  output logic              stall,
  output logic              bus_err
);

  acc_state_e        state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rbuf_q;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] mdr_q;
  logic              timed_out;
  logic              pc_en;
  logic [ADDR_W-1:0] pc_cur;

`ifdef MC_FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             bus_err_q;
  logic [CNT_W-1:0] wait_q;

  assign timed_out = bus_err_q;
`else
  logic unused_timeout_cfg;

  assign timed_out          = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Access FSM: latch the request in IDLE, hold the bus in BUSY until ack,
  // then commit read data to IR or MDR in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rbuf_q      <= '0;
      instr_q     <= '0;
      mdr_q       <= '0;
`ifdef MC_FETCH_TIMEOUT_EN
      bus_err_q   <= 1'b0;
      wait_q      <= '0;
`endif
    end else begin
      case (state_q)
        ACC_IDLE: begin
          if (!timed_out && (mem_rd || mem_wr)) begin
            mem_addr_q  <= IorD ? alu_out : pc_cur;
            mem_wdata_q <= wdata;
            mem_we_q    <= mem_wr;
            mem_req_q   <= 1'b1;
            state_q     <= ACC_BUSY;
`ifdef MC_FETCH_TIMEOUT_EN
            wait_q      <= '0;
`endif
          end
        end
        ACC_BUSY: begin
          if (mem_ack) begin
            if (!mem_we_q) rbuf_q <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= ACC_DONE;
          end
`ifdef MC_FETCH_TIMEOUT_EN
          else if (wait_q == WAIT_LAST) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            bus_err_q <= 1'b1;
            state_q   <= ACC_IDLE;
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
`endif
        end
        ACC_DONE: begin
          if (!mem_we_q) begin
            if (IRWrite) instr_q <= rbuf_q;
            else         mdr_q   <= rbuf_q;
          end
          mem_we_q <= 1'b0;
          state_q  <= ACC_IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          state_q   <= ACC_IDLE;
        end
      endcase
    end
  end

  // Hold the controller while a request is pending or in flight, or forever
  // once the bus has timed out.
  always_comb begin
    stall = timed_out;
    if (state_q == ACC_BUSY) stall = 1'b1;
    if ((state_q == ACC_IDLE) && (mem_rd || mem_wr)) stall = 1'b1;
  end

  assign pc_en = (PCWrite | (Branch & zero)) & ~stall;

  mc_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .en_i         (pc_en),
    .src_i        (PCSrc),
    .alu_result_i (alu_result),
    .alu_out_i    (alu_out),
    .jump_idx_i   (instr_q[25:0]),
    .pc_o         (pc_cur)
  );

  assign pc        = pc_cur;
  assign instr     = instr_q;
  assign mdr       = mdr_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign bus_err   = timed_out;

endmodule

// File: tb/tb_mc_fetch_unit.sv
// Directed testbench for mc_fetch_unit: fetch, multi-wait load, store,
// branch, jump, reset mid-transaction and the wait-state limit behaviour.
module tb_mc_fetch_unit;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr, IorD, IRWrite, PCWrite, Branch, zero;
  logic [1:0]  PCSrc;
  logic [31:0] alu_result, alu_out, wdata, mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we, stall, bus_err;
  logic [31:0] mem_addr, mem_wdata, pc, instr, mdr;

  int checkCount = 0;
  int passCount  = 0;

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  mc_fetch_unit #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .RESET_PC       (32'h0),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .IorD       (IorD),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .Branch     (Branch),
    .PCSrc      (PCSrc),
    .alu_result (alu_result),
    .alu_out    (alu_out),
    .zero       (zero),
    .wdata      (wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .pc         (pc),
    .instr      (instr),
    .mdr        (mdr),
    .stall      (stall),
    .bus_err    (bus_err)
  );

  // Advance n clock edges, landing 1 unit after the last rising edge.
  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive the controller strobes and let combinational outputs settle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic iord,
                               input logic irw, input logic pcw, input logic br,
                               input logic [1:0] src);
    mem_rd  = rd;
    mem_wr  = wr;
    IorD    = iord;
    IRWrite = irw;
    PCWrite = pcw;
    Branch  = br;
    PCSrc   = src;
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
  endtask

  // Global time limit so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  // Directed test sequence.
  initial begin
    rst = 1'b1; mem_ack = 1'b0; zero = 1'b0;
    alu_result = '0; alu_out = '0; wdata = '0; mem_rdata = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, PCSRC_ALU);
    waitCycles(2);
    rst = 1'b0;
    #1;

    $display("[TB] reset values");
    checkOutput("rst_pc",        pc,        32'h0);
    checkOutput("rst_instr",     instr,     32'h0);
    checkOutput("rst_mdr",       mdr,       32'h0);
    checkOutput("rst_mem_req",   mem_req,   32'h0);
    checkOutput("rst_mem_we",    mem_we,    32'h0);
    checkOutput("rst_mem_addr",  mem_addr,  32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_bus_err",   bus_err,   32'h0);
    checkOutput("rst_stall",     stall,     32'h0);

    $display("[TB] fetch, zero wait states");
    alu_result = 32'h4;
    mem_rdata  = 32'h8C22_0004;
    applyStimulus(1, 0, 0, 1, 1, 0, PCSRC_ALU);
    checkOutput("fetch_stall_idle", stall, 32'h1);
    waitCycles(1);
    mem_ack = 1'b1;
    #1;
    checkOutput("fetch_stall_busy", stall,    32'h1);
    checkOutput("fetch_req_busy",   mem_req,  32'h1);
    checkOutput("fetch_addr",       mem_addr, 32'h0);
    checkOutput("fetch_pc_frozen",  pc,       32'h0);
    waitCycles(1);
    mem_ack = 1'b0;
    applyStimulus(0, 0, 0, 1, 1, 0, PCSRC_ALU);
    checkOutput("fetch_stall_done", stall,   32'h0);
    checkOutput("fetch_req_done",   mem_req, 32'h0);
    waitCycles(1);
    applyStimulus(0, 0, 0, 0, 0, 0, PCSRC_ALU);
    checkOutput("fetch_instr", instr, 32'h8C22_0004);
    checkOutput("fetch_pc",    pc,    32'h4);

    $display("[TB] load with three wait states");
    alu_out   = 32'h100;
    mem_rdata = 32'h1234_5678;
    applyStimulus(1, 0, 1, 0, 0, 0, PCSRC_ALU);
    waitCycles(1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("load_addr", mem_addr, 32'h100);
      checkOutput("load_req",  mem_req,  32'h1);
      if (i == 3) mem_ack = 1'b1;
      waitCycles(1);
    end
    mem_ack = 1'b0;
    applyStimulus(0, 0, 1, 0, 0, 0, PCSRC_ALU);
    checkOutput("load_req_done", mem_req, 32'h0);
    waitCycles(1);
    checkOutput("load_mdr",   mdr,   32'h1234_5678);
    checkOutput("load_instr", instr, 32'h8C22_0004);

    $display("[TB] store");
    alu_out   = 32'h200;
    wdata     = 32'hDEAD_BEEF;
    mem_rdata = 32'hFFFF_FFFF;
    applyStimulus(0, 1, 1, 0, 0, 0, PCSRC_ALU);
    waitCycles(1);
    wdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      checkOutput("store_we",    mem_we,    32'h1);
      checkOutput("store_wdata", mem_wdata, 32'hDEAD_BEEF);
      checkOutput("store_addr",  mem_addr,  32'h200);
      if (i == 1) mem_ack = 1'b1;
      waitCycles(1);
    end
    mem_ack = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, PCSRC_ALU);
    waitCycles(1);
    checkOutput("store_mdr",   mdr,   32'h1234_5678);
    checkOutput("store_instr", instr, 32'h8C22_0004);

    $display("[TB] branch");
    alu_out = 32'h40;
    zero    = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1, PCSRC_ALUOUT);
    checkOutput("branch_stall", stall, 32'h0);
    waitCycles(1);
    checkOutput("branch_not_taken", pc, 32'h4);
    zero = 1'b1;
    waitCycles(1);
    checkOutput("branch_taken", pc, 32'h40);
    zero = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, PCSRC_ALU);

    $display("[TB] jump");
    alu_result = 32'h0040_0000;
    mem_rdata  = 32'h0800_0010;
    applyStimulus(1, 0, 0, 1, 1, 0, PCSRC_ALU);
    waitCycles(1);
    checkOutput("jfetch_addr", mem_addr, 32'h40);
    mem_ack = 1'b1;
    waitCycles(1);
    mem_ack = 1'b0;
    applyStimulus(0, 0, 0, 1, 1, 0, PCSRC_ALU);
    waitCycles(1);
    applyStimulus(0, 0, 0, 0, 0, 0, PCSRC_ALU);
    checkOutput("jfetch_pc",    pc,    32'h0040_0000);
    checkOutput("jfetch_instr", instr, 32'h0800_0010);
    applyStimulus(0, 0, 0, 0, 1, 0, PCSRC_JUMP);
    waitCycles(1);
    checkOutput("jump_pc", pc, 32'h40);
    alu_result = 32'h999;
    applyStimulus(0, 0, 0, 0, 1, 0, PCSRC_HOLD);
    waitCycles(1);
    checkOutput("hold_pc", pc, 32'h40);

    $display("[TB] ack ignored in idle");
    applyStimulus(0, 0, 0, 0, 0, 0, PCSRC_ALU);
    mem_ack = 1'b1;
    waitCycles(1);
    checkOutput("idle_ack_req",   mem_req, 32'h0);
    checkOutput("idle_ack_stall", stall,   32'h0);
    mem_ack = 1'b0;

    $display("[TB] reset during busy");
    alu_result = 32'h44;
    applyStimulus(1, 0, 0, 1, 1, 0, PCSRC_ALU);
    waitCycles(1);
    checkOutput("rbusy_req_before", mem_req, 32'h1);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("rbusy_req",   mem_req, 32'h0);
    checkOutput("rbusy_pc",    pc,      32'h0);
    checkOutput("rbusy_instr", instr,   32'h0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, PCSRC_ALU);
    checkOutput("rbusy_stall", stall, 32'h0);

`ifdef MC_FETCH_TIMEOUT_EN
    $display("[TB] wait-state limit");
    begin
      int n;
      n = 0;
      applyStimulus(1, 0, 0, 0, 0, 0, PCSRC_ALU);
      waitCycles(1);
      while (bus_err !== 1'b1 && n < 40) begin
        waitCycles(1);
        n++;
      end
      checkOutput("to_cycles",  n,       32'd8);
      checkOutput("to_bus_err", bus_err, 32'h1);
      checkOutput("to_req",     mem_req, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, PCSRC_ALU);
      waitCycles(3);
      checkOutput("to_stall_stuck", stall,   32'h1);
      checkOutput("to_err_sticky",  bus_err, 32'h1);
      rst = 1'b1;
      waitCycles(1);
      rst = 1'b0;
      #1;
      checkOutput("to_err_cleared", bus_err, 32'h0);
    end
`else
    $display("[TB] long wait without limit");
    applyStimulus(1, 0, 0, 0, 0, 0, PCSRC_ALU);
    waitCycles(21);
    checkOutput("lw_req",     mem_req, 32'h1);
    checkOutput("lw_stall",   stall,   32'h1);
    checkOutput("lw_bus_err", bus_err, 32'h0);
    mem_ack = 1'b1;
    waitCycles(1);
    mem_ack = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, PCSRC_ALU);
    waitCycles(1);
    checkOutput("lw_stall_end", stall, 32'h0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
